// File: rtl/updown_round_sequencer.sv
// updown_round_sequencer
// Round controller for the up/down number-guessing game. Draws a secret
// from a free-running LFSR (or a fixed debug value), captures guesses on
// rising trigger edges, registers the comparator verdict as a hint, counts
// remaining tries and declares win or lose.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start             level; begins a round from IDLE/WIN/LOSE
//   guess_trigger     rising edge submits user_number
//   user_number       player's guess
//   fixed_secret_en   select fixed_secret instead of the LFSR
//   fixed_secret      debug secret
//   cmp_result        comparator verdict: 00 eq, 01 guess<secret, 10 guess>secret
//   secret_number     registered secret to the comparator
//   guess_number      registered guess to the comparator
//   hint              verdict code: none, go up, go down, or out-of-range guess
//   tries_left        remaining guesses
//   busy              high in GEN/EVAL/SHOW
//   win, game_over    round outcome flags
module updown_round_sequencer #(
    parameter int MAX_NUM       = 99,
    parameter int MAX_TRIES     = 7,
    parameter int REVEAL_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       guess_trigger,
    input  logic [6:0] user_number,
    input  logic       fixed_secret_en,
    input  logic [6:0] fixed_secret,
    input  logic [1:0] cmp_result,
    output logic [6:0] secret_number,
    output logic [6:0] guess_number,
    output logic [1:0] hint,
    output logic [3:0] tries_left,
    output logic       busy,
    output logic       win,
    output logic       game_over
);
    localparam int CW = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;
    localparam logic [6:0]    MAX_V   = 7'(MAX_NUM);
    localparam logic [3:0]    TRIES_V = 4'(MAX_TRIES);
    localparam logic [CW-1:0] CNT_V   = CW'(REVEAL_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, GEN, WAIT_GUESS, EVAL, SHOW, WIN, LOSE
    } state_t;

    state_t        state_q, state_d;
    logic [6:0]    secret_q, secret_d;
    logic [6:0]    guess_q, guess_d;
    logic [1:0]    hint_q, hint_d;
    logic [3:0]    tries_q, tries_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    lfsr_q, lfsr_d;
    logic          trig_q;

    logic       trig_edge;
    logic [6:0] cand;
    logic [3:0] tries_dec;

    assign trig_edge = guess_trigger & ~trig_q;

    always_comb begin
        state_d   = state_q;
        secret_d  = secret_q;
        guess_d   = guess_q;
        hint_d    = hint_q;
        tries_d   = tries_q;
        cnt_d     = cnt_q;
        // x^7+x^6+1, free-running in every state
        lfsr_d    = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
        cand      = fixed_secret_en ? fixed_secret : lfsr_q;
        tries_dec = tries_q - 4'd1;

        case (state_q)
            IDLE: if (start) state_d = GEN;
            GEN: begin
                // Out-of-range candidates retry; a bad fixed secret stalls here.
                if (cand != 7'd0 && cand <= MAX_V) begin
                    secret_d = cand;
                    tries_d  = TRIES_V;
                    hint_d   = 2'b00;
                    guess_d  = 7'd0;
                    state_d  = WAIT_GUESS;
                end
            end
            WAIT_GUESS: begin
                if (trig_edge) begin
                    if (user_number == 7'd0 || user_number > MAX_V) begin
                        hint_d  = 2'b11;
                        cnt_d   = CNT_V;
                        state_d = SHOW;
                    end else begin
                        guess_d = user_number;
                        state_d = EVAL;
                    end
                end
            end
            EVAL: begin
                // guess_number is now stable at the comparator
                tries_d = tries_dec;
                if (cmp_result == 2'b00) begin
                    hint_d  = 2'b00;
                    state_d = WIN;
                end else begin
                    hint_d = (cmp_result == 2'b01) ? 2'b01 : 2'b10;
                    if (tries_dec == 4'd0) begin
                        state_d = LOSE;
                    end else begin
                        cnt_d   = CNT_V;
                        state_d = SHOW;
                    end
                end
            end
            SHOW: begin
                if (cnt_q == '0) state_d = WAIT_GUESS;
                else             cnt_d   = cnt_q - 1'b1;
            end
            WIN, LOSE: if (start) state_d = GEN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            secret_q <= 7'd0;
            guess_q  <= 7'd0;
            hint_q   <= 2'b00;
            tries_q  <= 4'd0;
            cnt_q    <= '0;
            lfsr_q   <= 7'h5A;
            trig_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            secret_q <= secret_d;
            guess_q  <= guess_d;
            hint_q   <= hint_d;
            tries_q  <= tries_d;
            cnt_q    <= cnt_d;
            lfsr_q   <= lfsr_d;
            trig_q   <= guess_trigger;
        end
    end

    assign secret_number = secret_q;
    assign guess_number  = guess_q;
    assign hint          = hint_q;
    assign tries_left    = tries_q;
    assign busy          = (state_q == GEN) || (state_q == EVAL) || (state_q == SHOW);
    assign win           = (state_q == WIN);
    assign game_over     = (state_q == WIN) || (state_q == LOSE);
endmodule

// File: tb/tb_updown_round_sequencer.sv
// Testbench for updown_round_sequencer. Two instances share all stimulus:
// u0 uses the default MAX_TRIES=7, u1 uses MAX_TRIES=3 for the lose round.
// Each instance sees a behavioural comparator built from its own outputs.
module tb_updown_round_sequencer;
    logic       clk = 1'b0;
    logic       reset, start, guess_trigger, fixed_secret_en;
    logic [6:0] user_number, fixed_secret;

    logic [1:0] cmp0, cmp1, hint_a, hint_b;
    logic [6:0] sec0, sec1, g0, g1;
    logic [3:0] tries0, tries1;
    logic       busy0, busy1, win0, win1, go0, go1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct { logic [1:0] hint; logic [3:0] tries; } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    assign cmp0 = (g0 == sec0) ? 2'b00 : (g0 < sec0) ? 2'b01 : 2'b10;
    assign cmp1 = (g1 == sec1) ? 2'b00 : (g1 < sec1) ? 2'b01 : 2'b10;

    updown_round_sequencer u0 (
        .clk(clk), .reset(reset), .start(start), .guess_trigger(guess_trigger),
        .user_number(user_number), .fixed_secret_en(fixed_secret_en),
        .fixed_secret(fixed_secret), .cmp_result(cmp0), .secret_number(sec0),
        .guess_number(g0), .hint(hint_a), .tries_left(tries0), .busy(busy0),
        .win(win0), .game_over(go0));

    updown_round_sequencer #(.MAX_TRIES(3)) u1 (
        .clk(clk), .reset(reset), .start(start), .guess_trigger(guess_trigger),
        .user_number(user_number), .fixed_secret_en(fixed_secret_en),
        .fixed_secret(fixed_secret), .cmp_result(cmp1), .secret_number(sec1),
        .guess_number(g1), .hint(hint_b), .tries_left(tries1), .busy(busy1),
        .win(win1), .game_over(go1));

    function automatic logic [6:0] lfsr_next(input logic [6:0] l);
        return {l[5:0], l[6] ^ l[5]};
    endfunction

    task automatic apply_reset();
        reset = 1'b1; start = 1'b0; guess_trigger = 1'b0;
        user_number = 7'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_ready(input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy0 && !busy1) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL %s: timeout waiting for busy=0, got busy0=%b busy1=%b required 0", nm, busy0, busy1);
        end
    endtask

    task automatic start_round(input logic [6:0] fs);
        fixed_secret_en = 1'b1; fixed_secret = fs;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_ready("start_round");
    endtask

    // Submit a guess; expected verdict goes on the scoreboard and is popped
    // one cycle after the edge is sampled. sel picks the instance checked.
    task automatic do_guess(input logic [6:0] n, input logic [1:0] eh,
                            input logic [3:0] et, input bit sel, input string nm);
        exp_t e, p;
        logic [1:0] ah; logic [3:0] at;
        wait_ready(nm);
        e.hint = eh; e.tries = et; sb.push_back(e);
        user_number = n; guess_trigger = 1'b1;
        @(posedge clk);
        @(negedge clk); guess_trigger = 1'b0;
        @(posedge clk); #1;
        p = sb.pop_front();
        ah = sel ? hint_b : hint_a; at = sel ? tries1 : tries0;
        n_checks++;
        if (ah !== p.hint) begin n_fail++; $display("FAIL %s hint: got %b required %b", nm, ah, p.hint); end
        n_checks++;
        if (at !== p.tries) begin n_fail++; $display("FAIL %s tries: got %0d required %0d", nm, at, p.tries); end
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({sec0, g0, hint_a, tries0, busy0, win0, go0} !== 23'd0) begin
            n_fail++; $display("FAIL reset_state: got %h required 0", {sec0, g0, hint_a, tries0, busy0, win0, go0});
        end
        start_round(7'd15);
        do_guess(7'd50, 2'b10, 4'd6, 1'b0, "rst_g1");
        @(negedge clk); #2;  // in SHOW, away from any edge
        reset = 1'b1; #1;
        n_checks++;
        if ({sec0, g0, hint_a, tries0, busy0, win0, go0} !== 23'd0) begin
            n_fail++; $display("FAIL reset_midround: got %h required 0", {sec0, g0, hint_a, tries0, busy0, win0, go0});
        end
        @(negedge clk); reset = 1'b0;
        start_round(7'd15);
        n_checks++;
        if (tries0 !== 4'd7 || busy0 !== 1'b0) begin
            n_fail++; $display("FAIL reset_restart: got tries=%0d busy=%b required 7/0", tries0, busy0);
        end
    endtask

    task automatic test_win();
        apply_reset();
        start_round(7'd15);
        do_guess(7'd50, 2'b10, 4'd6, 1'b0, "win_g1");
        do_guess(7'd10, 2'b01, 4'd5, 1'b0, "win_g2");
        do_guess(7'd15, 2'b00, 4'd4, 1'b0, "win_g3");
        n_checks++;
        if (win0 !== 1'b1 || go0 !== 1'b1) begin
            n_fail++; $display("FAIL win_flags: got win=%b go=%b required 1/1", win0, go0);
        end
    endtask

    task automatic test_lose();
        apply_reset();
        start_round(7'd15);
        do_guess(7'd1, 2'b01, 4'd2, 1'b1, "lose_g1");
        do_guess(7'd2, 2'b01, 4'd1, 1'b1, "lose_g2");
        do_guess(7'd3, 2'b01, 4'd0, 1'b1, "lose_g3");
        n_checks++;
        if (go1 !== 1'b1 || win1 !== 1'b0) begin
            n_fail++; $display("FAIL lose_flags: got go=%b win=%b required 1/0", go1, win1);
        end
        repeat (3) @(negedge clk);
        user_number = 7'd15; guess_trigger = 1'b1;
        @(negedge clk); guess_trigger = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({hint_b, tries1, g1, go1, win1} !== {2'b01, 4'd0, 7'd3, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL lose_hold: got hint=%b tries=%0d guess=%0d go=%b win=%b required 01/0/3/1/0",
                               hint_b, tries1, g1, go1, win1);
        end
    endtask

    task automatic test_out_of_range();
        apply_reset();
        start_round(7'd15);
        do_guess(7'd0,   2'b11, 4'd7, 1'b0, "oor_zero");
        n_checks++;
        if (g0 !== 7'd0) begin n_fail++; $display("FAIL oor_zero_guess: got %0d required 0", g0); end
        do_guess(7'd120, 2'b11, 4'd7, 1'b0, "oor_120");
        n_checks++;
        if (g0 !== 7'd0) begin n_fail++; $display("FAIL oor_120_guess: got %0d required 0", g0); end
    endtask

    task automatic test_trigger_filter();
        exp_t e, p;
        apply_reset();
        start_round(7'd15);
        e.hint = 2'b10; e.tries = 4'd6; sb.push_back(e);
        user_number = 7'd50; guess_trigger = 1'b1;
        repeat (20) @(negedge clk);
        guess_trigger = 1'b0;
        p = sb.pop_front();
        n_checks++;
        if (hint_a !== p.hint || tries0 !== p.tries || busy0 !== 1'b0) begin
            n_fail++; $display("FAIL trig_hold: got hint=%b tries=%0d busy=%b required %b/%0d/0",
                               hint_a, tries0, busy0, p.hint, p.tries);
        end
        do_guess(7'd10, 2'b01, 4'd5, 1'b0, "trig_g2");
        @(negedge clk); @(negedge clk);
        user_number = 7'd15; guess_trigger = 1'b1;  // pulse while in SHOW
        @(negedge clk); guess_trigger = 1'b0;
        wait_ready("trig_show");
        repeat (5) @(negedge clk);
        n_checks++;
        if (tries0 !== 4'd5 || hint_a !== 2'b01 || win0 !== 1'b0) begin
            n_fail++; $display("FAIL trig_show_pulse: got tries=%0d hint=%b win=%b required 5/01/0", tries0, hint_a, win0);
        end
    endtask

    task automatic test_lfsr();
        logic [6:0] l;
        apply_reset();
        fixed_secret_en = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_ready("lfsr_draw");
        // one shift before start, one on the IDLE->GEN edge
        l = lfsr_next(lfsr_next(7'h5A));
        while (l == 7'd0 || l > 7'd99) l = lfsr_next(l);
        n_checks++;
        if (sec0 !== l) begin n_fail++; $display("FAIL lfsr_secret: got %0d required %0d", sec0, l); end
        n_checks++;
        if (tries0 !== 4'd7) begin n_fail++; $display("FAIL lfsr_tries: got %0d required 7", tries0); end
    endtask

    task automatic test_stall();
        apply_reset();
        fixed_secret_en = 1'b1; fixed_secret = 7'd0;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (busy0 !== 1'b1 || sec0 !== 7'd0) begin
            n_fail++; $display("FAIL gen_stall: got busy=%b secret=%0d required 1/0", busy0, sec0);
        end
        fixed_secret = 7'd100;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy0 !== 1'b1 || sec0 !== 7'd0) begin
            n_fail++; $display("FAIL gen_stall_100: got busy=%b secret=%0d required 1/0", busy0, sec0);
        end
        fixed_secret = 7'd99;
        @(negedge clk);
        n_checks++;
        if (busy0 !== 1'b0 || sec0 !== 7'd99) begin
            n_fail++; $display("FAIL gen_release: got busy=%b secret=%0d required 0/99", busy0, sec0);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; guess_trigger = 1'b0;
        user_number = 7'd0; fixed_secret_en = 1'b1; fixed_secret = 7'd15;
        #1;
        test_reset();
        test_win();
        test_lose();
        test_out_of_range();
        test_trigger_filter();
        test_lfsr();
        test_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
